// File: rtl/fetch_stage.sv
// RV32I fetch stage and IF/ID register: credit-limited imem requests, in-order response queue,
// stale-response dropping after redirects. Define FETCH_PERF_EN to add bubble/drop counters.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchEmptyF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int unsigned AW  = $clog2(QDEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } qent_t;

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, qcnt_q, qcnt_d;
  logic [AW-1:0]   qrd_q, qrd_d, qwr_q, qwr_d, trd_q, trd_d, twr_q, twr_d;
  logic [31:0]     instrd_q, instrd_d;
  logic [XLEN-1:0] pcd_q, pcd_d, pcplus4d_q, pcplus4d_d;
  logic            validd_q, validd_d;

  qent_t           q_mem   [QDEPTH];
  logic [XLEN-1:0] tag_mem [QDEPTH];

  logic  accept, rsp_keep, rsp_drop, d_load, q_empty, pop, push, bypass;
  qent_t head;

  always_comb begin
    d_load         = !FlushD && !StallD;
    q_empty        = (qcnt_q == '0);
    head           = q_mem[qrd_q];
    // Credits cover both in-flight requests and queued words, so a response always has a slot.
    imem_req_valid = rst_n && !StallF && !PCSrcE && ((out_q + qcnt_q) < CW'(QDEPTH));
    imem_req_addr  = pcf_q;
    accept         = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (drop_q == '0) && !PCSrcE;
    rsp_drop       = imem_rsp_valid && !rsp_keep;
    pop            = d_load && !q_empty;
    bypass         = d_load && q_empty && rsp_keep;
    push           = rsp_keep && !bypass;
    FetchEmptyF    = q_empty && !rsp_keep;
  end

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    pcf_d      = pcf_q;
    out_d      = out_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    qcnt_d     = qcnt_q + CW'(push) - CW'(pop);
    qrd_d      = qrd_q + AW'(pop);
    qwr_d      = qwr_q + AW'(push);
    trd_d      = trd_q + AW'(rsp_keep);
    twr_d      = twr_q + AW'(accept);
    instrd_d   = instrd_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;

    if (PCSrcE) begin
      // Everything still owed by memory belongs to the abandoned path.
      pcf_d  = PCTargetE;
      drop_d = out_q - CW'(imem_rsp_valid);
      qcnt_d = '0;
      qrd_d  = '0;
      qwr_d  = '0;
      trd_d  = '0;
      twr_d  = '0;
    end else begin
      if (accept) pcf_d = pcf_q + XLEN'(4);
      if (rsp_drop) drop_d = drop_q - CW'(1);
    end

    if (FlushD) begin
      instrd_d = NOP;
      validd_d = 1'b0;
    end else if (!StallD) begin
      if (!q_empty) begin
        instrd_d   = head.instr;
        pcd_d      = head.pc;
        pcplus4d_d = head.pc + XLEN'(4);
        validd_d   = 1'b1;
      end else if (rsp_keep) begin
        instrd_d   = imem_rsp_data;
        pcd_d      = tag_mem[trd_q];
        pcplus4d_d = tag_mem[trd_q] + XLEN'(4);
        validd_d   = 1'b1;
      end else begin
        instrd_d = NOP;
        validd_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q      <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      qcnt_q     <= '0;
      qrd_q      <= '0;
      qwr_q      <= '0;
      trd_q      <= '0;
      twr_q      <= '0;
      instrd_q   <= NOP;
      pcd_q      <= '0;
      pcplus4d_q <= XLEN'(4);
      validd_q   <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      qcnt_q     <= qcnt_d;
      qrd_q      <= qrd_d;
      qwr_q      <= qwr_d;
      trd_q      <= trd_d;
      twr_q      <= twr_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers and counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push)   q_mem[qwr_q]   <= '{pc: tag_mem[trd_q], instr: imem_rsp_data};
    if (accept) tag_mem[twr_q] <= pcf_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) assert (qcnt_q != CW'(QDEPTH));
  end

  assign InstrD   = instrd_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcplus4d_q;
  assign ValidD   = validd_q;

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_q, bubble_d, dropc_q, dropc_d;

  always_comb begin
    bubble_d = bubble_q;
    dropc_d  = dropc_q;
    if (d_load && q_empty && !rsp_keep && (bubble_q != '1)) bubble_d = bubble_q + 32'd1;
    if (rsp_drop && (dropc_q != '1)) dropc_d = dropc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
      dropc_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      dropc_q  <= dropc_d;
    end
  end

  assign perf_bubble_cnt = bubble_q;
  assign perf_drop_cnt   = dropc_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural in-order memory with programmable latency plus a
// scoreboard of accepted fetch PCs that must reach decode in order.
module tb_fetch_stage;

  logic        clk, rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchEmptyF;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_drop_cnt;
  int          exp_bubble, exp_drop;
`endif

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD),
    .FetchEmptyF    (FetchEmptyF)
`ifdef FETCH_PERF_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] sb[$];
  logic [31:0] exp_pcf;
  int          cyc, mem_lat;
  int          checks, failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_rsp();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // One clock: sample handshakes at the falling edge, update memory/scoreboard after the rising edge.
  task automatic step();
    logic        acc, rsp, redir, dload;
    logic [31:0] a, tgt, e;
    int          c;
    @(negedge clk);
    acc   = imem_req_valid && imem_req_ready;
    a     = imem_req_addr;
    rsp   = imem_rsp_valid;
    redir = PCSrcE;
    tgt   = PCTargetE;
    dload = !StallD && !FlushD;
`ifdef FETCH_PERF_EN
    if (dload && FetchEmptyF) exp_bubble++;
    if (redir) exp_drop += mq.size();
`endif
    c = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (rsp) void'(mq.pop_front());
    if (redir) begin
      sb.delete();
      exp_pcf = tgt;
    end
    if (acc) begin
      mreq_t m;
      m.addr = a;
      m.due  = c + mem_lat;
      mq.push_back(m);
      sb.push_back(a);
      exp_pcf = exp_pcf + 32'd4;
    end
    drive_rsp();
    #1;
    check("req_addr", imem_req_addr, exp_pcf);
    if (dload && ValidD === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL d_unexpected observed_pc=%h expected=no_instruction", PCD);
      end else begin
        e = sb.pop_front();
        check("d_pc", PCD, e);
        check("d_instr", InstrD, word_of(e));
        check("d_pc4", PCPlus4D, e + 32'd4);
      end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cyc     = 0;
    exp_pcf = 32'h0;
    sb.delete();
    mq.delete();
    drive_rsp();
    #1;
  endtask

  initial begin
    logic [31:0] hold, exp_head;
    bit          found;
    checks = 0; failures = 0;
    rst_n = 1'b0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    mem_lat = 1; cyc = 0; exp_pcf = '0;
`ifdef FETCH_PERF_EN
    exp_bubble = 0; exp_drop = 0;
`endif
    #12;
    check("rst_instr", InstrD, 32'h0000_0013);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pc4", PCPlus4D, 32'h4);
    check("rst_valid", ValidD, 1'b0);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_empty", FetchEmptyF, 1'b1);

    // Zero-wait stream: request cycle 0, bypass into D visible at cycle 2.
    release_reset();
    check("c0_req_valid", imem_req_valid, 1'b1);
    check("c0_addr", imem_req_addr, 32'h0);
    step();
    check("c1_valid", ValidD, 1'b0);
    step();
    check("c2_valid", ValidD, 1'b1);
    check("c2_pcd", PCD, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stream_valid", ValidD, 1'b1);
    end
    check("stream_pcd", PCD, 32'h8);

    // Hold D for three cycles; credits must stop new requests.
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pcd", PCD, 32'h8);
      check("stall_valid", ValidD, 1'b1);
      if (i > 0) check("stall_credit", imem_req_valid, 1'b0);
    end
    StallD = 1'b0;
    step();
    check("unstall_pcd", PCD, 32'hC);

    // Flush and stall together: bubble, head stays queued.
    StallD = 1'b1; FlushD = 1'b1;
    exp_head = sb[0];
    step();
    check("flush_instr", InstrD, 32'h0000_0013);
    check("flush_valid", ValidD, 1'b0);
    StallD = 1'b0; FlushD = 1'b0;
    step();
    check("flush_head_valid", ValidD, 1'b1);
    check("flush_head_pcd", PCD, exp_head);

    // Redirect with two requests in flight on a 2-cycle memory.
    mem_lat = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = (mq.size() == 2);
    end
    assert (found)
    else begin
      failures++;
      $error("FAIL wait_two_outstanding observed=timeout expected=2_in_flight");
    end
    checks++;
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100;
    #1;
    check("redir_no_req", imem_req_valid, 1'b0);
    step();
    PCSrcE = 1'b0; FlushD = 1'b0;
    #1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = (ValidD === 1'b1);
    end
    check("redir_pcd", PCD, 32'h100);
`ifdef FETCH_PERF_EN
    check("perf_drop", perf_drop_cnt, 32'(exp_drop));
`endif

    // Memory refuses requests for four cycles.
    mem_lat = 1;
    for (int i = 0; i < 4; i++) step();
    StallF = 1'b1;
    #1;
    check("stallf_req", imem_req_valid, 1'b0);
    StallF = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    hold = exp_pcf;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("notready_addr", imem_req_addr, hold);
      if (i >= 3) begin
        check("notready_valid", ValidD, 1'b0);
        check("notready_empty", FetchEmptyF, 1'b1);
      end
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
`ifdef FETCH_PERF_EN
    check("perf_bubble", perf_bubble_cnt, 32'(exp_bubble));
`endif

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    mq.delete();
    imem_rsp_valid = 1'b0;
    #1;
    check("arst_instr", InstrD, 32'h0000_0013);
    check("arst_valid", ValidD, 1'b0);
    check("arst_pcd", PCD, 32'h0);
    check("arst_pc4", PCPlus4D, 32'h4);
    check("arst_req_valid", imem_req_valid, 1'b0);
    check("arst_addr", imem_req_addr, 32'h0);
`ifdef FETCH_PERF_EN
    check("arst_perf_bubble", perf_bubble_cnt, 32'h0);
    check("arst_perf_drop", perf_drop_cnt, 32'h0);
`endif
    release_reset();
    check("restart_addr", imem_req_addr, 32'h0);
    step();
    step();
    check("restart_valid", ValidD, 1'b1);
    check("restart_pcd", PCD, 32'h0);
    for (int i = 0; i < 3; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
